// File: rtl/alu_instr_sequencer.sv
// Micro-step control sequencer for a single-bus datapath.
// Walks one Ra <= Rb op Rc instruction through fetch T0-T2 and execute T3-T5.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int OP_W     = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [IDX_W-1:0]    ra,
  input  logic [IDX_W-1:0]    rb,
  input  logic [IDX_W-1:0]    rc,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [OP_W-1:0]  op_q;
  logic [IDX_W-1:0] ra_q;
  logic [IDX_W-1:0] rb_q;
  logic [IDX_W-1:0] rc_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = start ? S_T0 : S_IDLE;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = mem_ready ? S_T2 : S_T1;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_T4;
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One bus driver per step keeps the shared bus contention-free.
  always_comb begin
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    r_in     = '0;
    r_out    = '0;
    alu_op   = '0;
    done     = 1'b0;
    unique case (state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = mem_ready;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        r_out = ONE << rb_q;
        y_in  = 1'b1;
      end
      S_T4: begin
        r_out  = ONE << rc_q;
        alu_op = op_q;
        z_in   = 1'b1;
      end
      S_T5: begin
        zlow_out = 1'b1;
        r_in     = ONE << ra_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench for alu_instr_sequencer.
// Reference model derives each cycle's controls from time since launch.
module tb_alu_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        start;
  logic [3:0]  op, ra, rb, rc;
  logic        mem_ready;
  logic        pc_out, mar_in, inc_pc, pc_in;
  logic        read, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlow_out;
  logic [15:0] r_in, r_out;
  logic [3:0]  alu_op;
  logic        busy, done;

  alu_instr_sequencer dut (
    .clk(clk), .clr(clr), .start(start),
    .op(op), .ra(ra), .rb(rb), .rc(rc),
    .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in),
    .inc_pc(inc_pc), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in),
    .zlow_out(zlow_out),
    .r_in(r_in), .r_out(r_out),
    .alu_op(alu_op), .busy(busy),
    .done(done)
  );

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in;
    logic read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out;
    logic [15:0] r_in, r_out;
    logic [3:0] alu_op;
    logic busy, done;
  } ctl_t;

  typedef struct {
    int launch;
    int w;
    logic [3:0] op, ra, rb, rc;
  } ins_t;

  ins_t q[$];
  bit   forced_v[int];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   free_at = 0;
  bit   prev_clr = 1'b1;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected controls t cycles after the launching IDLE cycle.
  function automatic ctl_t model(input ins_t e, input int t);
    ctl_t m;
    int w;
    m = '0;
    w = e.w;
    m.busy = (t >= 1 && t <= 7 + w);
    if (t == 1) begin
      m.pc_out = 1; m.mar_in = 1;
      m.inc_pc = 1; m.z_in = 1;
    end else if (t >= 2 && t <= 2 + w) begin
      m.zlow_out = 1; m.pc_in = 1; m.read = 1;
      m.mdr_in = (t == 2 + w);
    end else if (t == 3 + w) begin
      m.mdr_out = 1; m.ir_in = 1;
    end else if (t == 4 + w) begin
      m.r_out = 16'(1) << e.rb; m.y_in = 1;
    end else if (t == 5 + w) begin
      m.r_out = 16'(1) << e.rc;
      m.alu_op = e.op; m.z_in = 1;
    end else if (t == 6 + w) begin
      m.zlow_out = 1; m.r_in = 16'(1) << e.ra;
    end else if (t == 7 + w) begin
      m.done = 1;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    ctl_t act, exp_c;
    int t, drv;
    bit at_end;
    if (mon_en) begin
      act = {pc_out, mar_in, inc_pc, pc_in,
             read, mdr_in, mdr_out, ir_in,
             y_in, z_in, zlow_out,
             r_in, r_out, alu_op, busy, done};
      exp_c = '0;
      t = 0;
      at_end = 1'b0;
      if (q.size() != 0) begin
        t = cyc - q[0].launch;
        exp_c = model(q[0], t);
        at_end = (t == 7 + q[0].w);
      end
      tests++;
      if (act !== exp_c) begin
        fails++;
        $display("FAIL ctl cyc=%0d t=%0d got=%h exp=%h",
                 cyc, t, act, exp_c);
      end
      if (done === 1'b1) begin
        tests++;
        if (!at_end) begin
          fails++;
          $display("FAIL done_pop cyc=%0d got done=1 exp none pending", cyc);
        end
      end
      if (at_end) void'(q.pop_front());
      drv = int'(pc_out) + int'(zlow_out) + int'(mdr_out) + $countones(r_out);
      tests++;
      if (drv > 1) begin
        fails++;
        $display("FAIL bus_drivers cyc=%0d got=%0d exp<=1", cyc, drv);
      end
    end
  end

  task automatic step(input bit c_clr, input bit c_start,
                      input logic [3:0] c_op, input logic [3:0] c_ra,
                      input logic [3:0] c_rb, input logic [3:0] c_rc,
                      input int c_w);
    ins_t e;
    @(posedge clk);
    #1;
    if (prev_clr) begin
      q.delete();
      free_at = cyc;
      mon_en = 1'b1;
    end
    clr = c_clr;
    start = c_start;
    op = c_op; ra = c_ra; rb = c_rb; rc = c_rc;
    mem_ready = forced_v.exists(cyc) ? forced_v[cyc] : 1'($urandom);
    if (!c_clr && c_start && cyc >= free_at) begin
      e.launch = cyc; e.w = c_w;
      e.op = c_op; e.ra = c_ra; e.rb = c_rb; e.rc = c_rc;
      q.push_back(e);
      for (int i = 0; i < c_w; i++) forced_v[cyc + 2 + i] = 1'b0;
      forced_v[cyc + 2 + c_w] = 1'b1;
      free_at = cyc + 8 + c_w;
    end
    prev_clr = c_clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 4'($urandom), 4'($urandom),
           4'($urandom), 4'($urandom), 0);
  endtask

  initial begin
    clr = 1; start = 1; mem_ready = 0;
    op = 0; ra = 0; rb = 0; rc = 0;
    step(1, 1, 4'd5, 4'd5, 4'd5, 4'd5, 0);
    step(1, 1, 4'd5, 4'd5, 4'd5, 4'd5, 0);
    idle(3);
    // basic run
    step(0, 1, 4'd3, 4'd1, 4'd2, 4'd4, 0);
    idle(10);
    // memory wait of three cycles
    step(0, 1, 4'd3, 4'd1, 4'd2, 4'd4, 3);
    idle(12);
    // start during T3 must be ignored
    step(0, 1, 4'd3, 4'd1, 4'd2, 4'd4, 0);
    idle(3);
    step(0, 1, 4'd9, 4'd7, 4'd7, 4'd7, 0);
    idle(8);
    // abort at T4, then a clean run
    step(0, 1, 4'd6, 4'd3, 4'd3, 4'd3, 0);
    idle(4);
    step(1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 0);
    idle(3);
    step(0, 1, 4'd2, 4'd15, 4'd0, 4'd15, 1);
    idle(12);
    // start held high
    for (int i = 0; i < 48; i++)
      step(0, 1, 4'($urandom), 4'($urandom),
           4'($urandom), 4'($urandom), 0);
    idle(10);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(3) == 0,
           4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), $urandom_range(4));
    idle(16);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Micro-step control sequencer for the single-bus datapath of 32-bit general registers, PC, MAR/MDR, IR, Y and Z.
- Runs one register-register ALU instruction (Ra <= Rb op Rc) through fetch steps T0-T2 and execute steps T3-T5.
- Drives the register enable and bus-drive select lines.
- Sits between the top-level start/decode logic and the datapath register file.

Parameters:
- NUM_REGS, 16, number of general registers; width of r_in/r_out.
- IDX_W, 4, register index width (log2 NUM_REGS).
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  request to run one instruction; sampled only in IDLE
- op  in  OP_W  ALU opcode; captured with start
- ra  in  IDX_W  destination register index; captured with start
- rb  in  IDX_W  source A register index; captured with start
- rc  in  IDX_W  source B register index; captured with start
- mem_ready  in  1  memory read data valid during T1
- pc_out, mar_in, inc_pc, pc_in  out  1  PC/MAR controls
- read, mdr_in, mdr_out, ir_in  out  1  memory/IR controls
- y_in, z_in, zlow_out  out  1  ALU operand/result register controls
- r_in  out  NUM_REGS  one-hot general register load enable
- r_out  out  NUM_REGS  one-hot general register bus drive
- alu_op  out  OP_W  opcode to ALU
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Clocking and reset:
  - One clock domain.
  - clr is synchronous and active-high, with priority over all other inputs.
  - On clr the state goes to IDLE and the captured op/ra/rb/rc registers go to 0.
  - All outputs are 0 in the cycle after the clr edge.
  - clr asserted mid-instruction aborts it; done is not pulsed.
- States: IDLE, T0, T1, T2, T3, T4, T5, DONE. State is held in registers.
- Outputs are decoded combinationally from state and captured fields. mdr_in is the only output that also depends on mem_ready.
- Transitions:
  - IDLE: if start=1, capture op/ra/rb/rc and go to T0; otherwise stay.
  - T0: pc_out=1, mar_in=1, inc_pc=1, z_in=1. Go to T1.
  - T1: zlow_out=1, pc_in=1, read=1, mdr_in=mem_ready. Stay in T1 while mem_ready=0; go to T2 when mem_ready=1. While waiting, pc_in and zlow_out stay asserted (reloading the same value is harmless).
  - T2: mdr_out=1, ir_in=1. Go to T3.
  - T3: r_out = one-hot(rb), y_in=1. Go to T4.
  - T4: r_out = one-hot(rc), alu_op = op, z_in=1. Go to T5.
  - T5: zlow_out=1, r_in = one-hot(ra). Go to DONE.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- alu_op is 0 outside T4. r_in is 0 outside T5. r_out is 0 outside T3/T4.
- At most one bus driver (pc_out, zlow_out, mdr_out, or any r_out bit) is active in any cycle.
- start while busy=1 is ignored. op/ra/rb/rc changes after capture have no effect.
- start=1 in the DONE cycle is ignored. start sampled in the following IDLE cycle launches the next instruction; minimum spacing is 8 cycles.
- Latency with mem_ready=1 throughout: start sampled at edge k puts T0 in cycle k+1, and done is high in cycle k+7. Each extra T1 wait cycle adds 1.
- ra, rb and rc may be equal (e.g. R3 <= R3 op R3); no special case.
- Indices cover 0..NUM_REGS-1; every index is legal.

Test Plan:
- Reset: hold clr=1 for 2 cycles with start=1 -> all outputs 0, busy=0, no state advance.
- Basic run: start=1 for one cycle with op=3, ra=1, rb=2, rc=4, mem_ready=1 ->
  - T3: r_out=16'h0004, y_in=1.
  - T4: r_out=16'h0010, alu_op=3, z_in=1.
  - T5: r_in=16'h0002, zlow_out=1.
  - done pulses at cycle k+7; busy high cycles k+1..k+7.
- Memory wait: mem_ready held 0 for 3 cycles in T1 ->
  - read=1 and mdr_in=0 for 3 cycles, then mdr_in=1 for one cycle.
  - done at k+10.
- Ignored start: pulse start with ra=7 during T3 -> r_in in T5 still selects the original ra (16'h0002); no second instruction follows.
- Abort: clr=1 at T4 -> next cycle state IDLE and all outputs 0; done never pulses; a new start runs normally.
- Back-to-back: start held high continuously -> instructions launch 8 cycles apart; done pulses every 8 cycles; every cycle has at most one active bus driver.
